// File: rtl/load_store_unit.sv
// Single-port load/store unit for RV32I accesses: word loads/stores go straight
// through, while byte/halfword stores read the word, merge the lane and write it back.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP} state_t;

    state_t      r_state, w_next;
    logic        r_store, r_err;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata, r_rdata;

    logic        w_accept, w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data, w_merged;

    assign w_accept = req_valid && (r_state == IDLE);

    // Illegal codes, stores with unsigned codes, and misaligned H/W accesses.
    always_comb begin
        w_err = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: w_err = 1'b1;
            3'b100:                 w_err = req_store;
            3'b101:                 w_err = req_store || req_addr[0];
            3'b001:                 w_err = req_addr[0];
            3'b010:                 w_err = (req_addr[1:0] != 2'b00);
            default:                w_err = 1'b0;
        endcase
    end

    assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = mem_rdata;
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = 32'h0;
        endcase
    end

    // r_rdata holds the word captured in RMW_RD; only the addressed lane changes.
    always_comb begin
        w_merged = r_rdata;
        if (r_funct3[1:0] == 2'b00)
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err)                       w_next = RESP;
                    else if (!req_store)             w_next = LOAD;
                    else if (req_funct3 == 3'b010)   w_next = WRITE;
                    else                             w_next = RMW_RD;
                end
            end
            LOAD:    w_next = RESP;
            WRITE:   w_next = RESP;
            RMW_RD:  w_next = RMW_WR;
            RMW_WR:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_store  <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_err    <= w_err;
                        r_rdata  <= 32'h0;
                    end
                end
                LOAD:    r_rdata <= w_load_data;
                RMW_RD:  r_rdata <= mem_rdata;
                RMW_WR:  r_rdata <= 32'h0;
                default: ;
            endcase
        end
    end

    // Strobes and the response are gated by rst so an abort never leaks a write.
    always_comb begin
        req_ready  = (r_state == IDLE);
        mem_read   = !rst && ((r_state == LOAD) || (r_state == RMW_RD));
        mem_write  = !rst && ((r_state == WRITE) || (r_state == RMW_WR));
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        resp_valid = !rst && (r_state == RESP);
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        if ((r_state == LOAD) || (r_state == WRITE) ||
            (r_state == RMW_RD) || (r_state == RMW_WR))
            mem_addr = {r_addr[31:2], 2'b00};
        if (r_state == WRITE)  mem_wdata = r_wdata;
        if (r_state == RMW_WR) mem_wdata = w_merged;
        if (resp_valid) begin
            resp_err   = r_err;
            resp_rdata = r_rdata;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    int total = 0;
    int bad   = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (poke_en)        mem[poke_idx] <= poke_val;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        tick();
        poke_en = 1'b0;
    endtask

    // Issue one request, then walk the fixed latency checking strobes and response.
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_nrd, input int exp_nwr, input logic [31:0] exp_wd);
        int nrd, nwr;
        nrd = 0; nwr = 0;
        chk({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            if (mem_read || mem_write)
                chk({tag, ".maddr"}, mem_addr, {a[31:2], 2'b00});
            if (mem_write)
                chk({tag, ".wdata"}, mem_wdata, exp_wd);
            chk({tag, ".vld"}, {31'h0, resp_valid}, (c == lat) ? 32'h1 : 32'h0);
            if (c == lat) begin
                chk({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
                chk({tag, ".rdata"}, resp_rdata, exp_rd);
            end
            tick();
        end
        chk({tag, ".nrd"}, nrd, exp_nrd);
        chk({tag, ".nwr"}, nwr, exp_nwr);
        chk({tag, ".done"}, {30'h0, resp_valid, req_ready}, 32'h1);
    endtask

    initial begin
        int acc, nwr, nresp;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        poke_en = 1'b0; poke_idx = 6'd0; poke_val = 32'h0;
        tick(); tick();
        chk("rst.strobes", {30'h0, mem_read, mem_write}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst.ready", {31'h0, req_ready}, 32'h1);
        chk("rst.resp", {30'h0, resp_valid, resp_err}, 32'h0);
        chk("rst.rdata", resp_rdata, 32'h0);
        chk("rst.maddr", mem_addr, 32'h0);
        chk("rst.mwdata", mem_wdata, 32'h0);

        poke(6'd4, 32'h88776655);
        do_req("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFF88, 1, 0, 32'h0);
        do_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 2, 1'b0, 32'h00008877, 1, 0, 32'h0);
        do_req("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h88776655, 1, 0, 32'h0);
        do_req("lh10",  1'b0, 3'b001, 32'h10, 32'h0, 2, 1'b0, 32'h00006655, 1, 0, 32'h0);
        do_req("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF8877, 1, 0, 32'h0);
        do_req("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 2, 1'b0, 32'h00000066, 1, 0, 32'h0);
        do_req("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 2, 1'b0, 32'h00000055, 1, 0, 32'h0);

        do_req("sb11", 1'b1, 3'b000, 32'h11, 32'h000000AB, 3, 1'b0, 32'h0, 1, 1, 32'h8877AB55);
        chk("sb11.mem", mem[4], 32'h8877AB55);
        do_req("sh12", 1'b1, 3'b001, 32'h12, 32'hCAFE1234, 3, 1'b0, 32'h0, 1, 1, 32'h1234AB55);
        chk("sh12.mem", mem[4], 32'h1234AB55);

        do_req("elw12", 1'b0, 3'b010, 32'h12, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0);
        do_req("esh13", 1'b1, 3'b001, 32'h13, 32'h5555, 1, 1'b1, 32'h0, 0, 0, 32'h0);
        do_req("ef011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0);
        do_req("esbu",  1'b1, 3'b100, 32'h10, 32'h77, 1, 1'b1, 32'h0, 0, 0, 32'h0);
        chk("err.mem", mem[4], 32'h1234AB55);

        do_req("sw20", 1'b1, 3'b010, 32'h20, 32'h01234567, 2, 1'b0, 32'h0, 0, 1, 32'h01234567);
        chk("sw20.mem", mem[8], 32'h01234567);

        // SH aborted by reset while the merged word is on the write port.
        poke(6'd4, 32'h88776655);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h10; req_wdata = 32'h00001234;
        tick();
        req_valid = 1'b0;
        chk("abt.rmwrd", {30'h0, mem_read, mem_write}, 32'h2);
        tick();
        chk("abt.rmwwr", {30'h0, mem_read, mem_write}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abt.gate", {30'h0, mem_write, resp_valid}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("abt.ready", {30'h0, resp_valid, req_ready}, 32'h1);
        chk("abt.mem", mem[4], 32'h88776655);
        tick();
        chk("abt.noresp", {31'h0, resp_valid}, 32'h0);

        // SW with req_valid held: re-accepted only on each return to IDLE.
        acc = 0; nwr = 0; nresp = 0;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            if (req_valid && req_ready) acc++;
            tick();
            if (mem_write)  nwr++;
            if (resp_valid) nresp++;
        end
        req_valid = 1'b0;
        chk("hold.acc", acc, 32'd2);
        chk("hold.nwr", nwr, 32'd2);
        chk("hold.nresp", nresp, 32'd2);
        chk("hold.mem", mem[8], 32'hDEADBEEF);
        tick();
        chk("hold.idle", {30'h0, req_ready, mem_write}, 32'h2);
        tick();
        chk("hold.quiet", {29'h0, mem_write, mem_read, resp_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
